cpu_run_ctrl: RTL
=================

// Module: cpu_run_ctrl
// PURPOSE
//  Run/step/halt sequencer for the 8-bit single-cycle cpu. Drives a clock enable gating
//  the PC and register-file updates, plus a synchronous reset, from
//  host commands. Adds PC breakpoints, halt-on-self-loop detection and an enabled-cycle
//  counter. Sits between the test host/top level and the cpu core.
// PARAMETERS
//  PC_W        8     width of pc / bp_addr
//  CNT_W       16    width of cycle_count
//  RST_CYCLES  2     cycles cpu_rst is held after reset or restart (>=1)
//  WDOG_LIMIT  1000  watchdog limit in enabled cycles (CPU_CTRL_WDOG_EN only)
// PORTS
//  clk          in   1      clock, rising edge
//  reset_n      in   1      asynchronous, active-low reset
//  run_req      in   1      level/pulse: start free-running
//  halt_req     in   1      pulse: stop after current cycle
//  step_req     in   1      pulse: execute exactly one instruction
//  restart_req  in   1      pulse: re-run reset sequence
//  bp_en        in   1      breakpoint enable
//  bp_addr      in   PC_W   breakpoint PC
//  pc           in   PC_W   cpu current PC (registered in core)
//  cpu_en       out  1      core update enable (PC + regfile write)
//  cpu_rst      out  1      synchronous reset to core
//  state_o      out  3      RST=0 IDLE=1 RUN=2 STEP=3 DONE=4 ERR=5
//  halted       out  1      state is IDLE, DONE or ERR
//  bp_hit       out  1      1-cycle pulse when a breakpoint stops RUN
//  done         out  1      sticky: self-loop detected
//  cycle_count  out  CNT_W  enabled (executed) cycles since last reset/restart
//  wdog_err     out  1      sticky watchdog flag (0 when macro off)
// BEHAVIOUR
//  Reset (reset_n=0): state=RST, rst_cnt=0, cycle_count=0, done=0, wdog_err=0,
//   bp_skip=0, pc_vld=0. Outputs therefore: cpu_rst=1, cpu_en=1, halted=0, bp_hit=0.
//  RST: cpu_rst=1, cpu_en=1 (core sync reset needs the edge). After RST_CYCLES cycles
//   -> IDLE. Commands other than restart_req ignored.
//  IDLE: cpu_en=0. Priority restart_req > step_req > run_req.
//  RUN: cpu_en = ~brk, brk = bp_en & (pc==bp_addr) & ~bp_skip (combinational from pc).
//   brk -> IDLE same cycle, bp_hit=1 for that cycle, bp_skip<=1.
//   halt_req -> IDLE; the current cycle still executes (cpu_en per brk).
//  STEP: cpu_en=1 for exactly one cycle (breakpoints ignored) -> IDLE.
//  bp_skip cleared on any enabled cycle; lets RUN/STEP leave a breakpointed PC.
//  Self-loop: pc_q<=pc, pc_vld<=1 on every enabled non-RST cycle; when pc_vld & pc==pc_q
//   and the previous cycle was enabled -> DONE, done<=1. Checked in RUN and after STEP.
//  DONE/ERR: cpu_en=0; only restart_req leaves (-> RST).
//  restart_req from any state -> RST: clears rst_cnt, cycle_count, done, bp_skip, pc_vld;
//   wdog_err cleared too. Reset mid-RUN is immediate; the core is gated same cycle.
//  Simultaneous in RUN: restart_req > halt_req > brk > self-loop; bp_hit only if brk won.
//  cycle_count: +1 per cpu_en=1 cycle outside RST; saturates at all-ones (no wrap).
//  pc wrap 0xFF->0x00 is normal execution, not a self-loop.
// CONFIGURATION
//  CPU_CTRL_WDOG_EN defined: RUN cycles since last entering RUN counted; reaching
//   WDOG_LIMIT -> ERR, wdog_err<=1 (sticky until restart/reset). Self-loop beats
//   watchdog in the same cycle.
//  Undefined: no watchdog counter, ERR unreachable, wdog_err tied 0.
// TESTING
//  reset_n low 3 cyc then high, RST_CYCLES=2 -> cpu_rst=1 for 2 cyc, state_o=1, cpu_en=0.
//  IDLE, step_req x3 -> exactly 3 cpu_en pulses, pc 0->3, cycle_count=3.
//  run_req, bp_en=1 bp_addr=0x05 -> stop with pc=0x05, bp_hit 1 cyc, cycle_count=5;
//   run_req again -> continues past 0x05 without re-hit.
//  Program ending in branch-to-self at 0x09 -> done=1, state_o=4, cpu_en=0, count frozen.
//  halt_req and brk same cycle in RUN -> IDLE, bp_hit=0; restart_req in DONE -> RST,
//   done=0, cycle_count=0.
//  WDOG_EN, WDOG_LIMIT=20, infinite loop 0x00<->0x01 -> state_o=5, wdog_err=1 at 20.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// Run/step/halt sequencer for the 8-bit single-cycle cpu: clock enable, core reset, breakpoints,
// self-loop halt and enabled-cycle counter. Watchdog included when CPU_CTRL_WDOG_EN is defined.
module cpu_run_ctrl #(
    parameter int unsigned PC_W       = 8,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned RST_CYCLES = 2,
    parameter int unsigned WDOG_LIMIT = 1000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             run_req,
    input  logic             halt_req,
    input  logic             step_req,
    input  logic             restart_req,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic [PC_W-1:0]  pc,
    output logic             cpu_en,
    output logic             cpu_rst,
    output logic [2:0]       state_o,
    output logic             halted,
    output logic             bp_hit,
    output logic             done,
    output logic [CNT_W-1:0] cycle_count,
    output logic             wdog_err
);

    localparam logic [2:0] ST_RST  = 3'd0;
    localparam logic [2:0] ST_IDLE = 3'd1;
    localparam logic [2:0] ST_RUN  = 3'd2;
    localparam logic [2:0] ST_STEP = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;
    localparam logic [2:0] ST_ERR  = 3'd5;

    localparam int unsigned RCNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(RST_CYCLES - 1);

    logic [2:0]        r_state;
    logic [RCNT_W-1:0] r_rst_cnt;
    logic [CNT_W-1:0]  r_cycle_count;
    logic              r_done;
    logic              r_bp_skip;
    logic [PC_W-1:0]   r_pc_q;
    logic              r_pc_vld;
    logic              r_prev_en;

    logic [2:0]        w_state_d;
    logic              w_cpu_en;
    logic              w_bp_hit;
    logic              w_brk;
    logic              w_loop;
    logic              w_wdog_fire;
    logic              w_exec;

    assign w_brk  = bp_en & (pc == bp_addr) & ~r_bp_skip;
    // Instruction that just executed branched to itself.
    assign w_loop = r_pc_vld & (pc == r_pc_q) & r_prev_en;
    assign w_exec = w_cpu_en & (r_state != ST_RST);

    always_comb begin
        w_state_d = r_state;
        w_cpu_en  = 1'b0;
        w_bp_hit  = 1'b0;
        case (r_state)
            ST_RST: begin
                w_cpu_en = 1'b1;
                if (!restart_req && r_rst_cnt == RCNT_LAST) begin
                    w_state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (restart_req) begin
                    w_state_d = ST_RST;
                end else if (w_loop) begin
                    w_state_d = ST_DONE;
                end else if (step_req) begin
                    w_state_d = ST_STEP;
                end else if (run_req) begin
                    w_state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (restart_req) begin
                    w_state_d = ST_RST;
                end else if (halt_req) begin
                    w_cpu_en  = ~w_brk;
                    w_state_d = ST_IDLE;
                end else if (w_brk) begin
                    w_bp_hit  = 1'b1;
                    w_state_d = ST_IDLE;
                end else if (w_loop) begin
                    w_state_d = ST_DONE;
                end else if (w_wdog_fire) begin
                    w_state_d = ST_ERR;
                end else begin
                    w_cpu_en = 1'b1;
                end
            end
            ST_STEP: begin
                if (restart_req) begin
                    w_state_d = ST_RST;
                end else begin
                    w_cpu_en  = 1'b1;
                    w_state_d = ST_IDLE;
                end
            end
            ST_DONE, ST_ERR: begin
                if (restart_req) begin
                    w_state_d = ST_RST;
                end
            end
            default: w_state_d = ST_RST;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_RST;
            r_rst_cnt     <= '0;
            r_cycle_count <= '0;
            r_done        <= 1'b0;
            r_bp_skip     <= 1'b0;
            r_pc_q        <= '0;
            r_pc_vld      <= 1'b0;
            r_prev_en     <= 1'b0;
        end else begin
            r_state <= w_state_d;
            if (restart_req) begin
                r_rst_cnt     <= '0;
                r_cycle_count <= '0;
                r_done        <= 1'b0;
                r_bp_skip     <= 1'b0;
                r_pc_vld      <= 1'b0;
                r_prev_en     <= 1'b0;
            end else begin
                if (r_state == ST_RST && w_state_d == ST_RST) begin
                    r_rst_cnt <= r_rst_cnt + 1'b1;
                end
                if (w_exec) begin
                    if (r_cycle_count != {CNT_W{1'b1}}) begin
                        r_cycle_count <= r_cycle_count + 1'b1;
                    end
                    r_pc_q    <= pc;
                    r_pc_vld  <= 1'b1;
                    r_bp_skip <= 1'b0;
                end
                // Lets the next RUN/STEP leave the breakpointed PC.
                if (w_bp_hit) begin
                    r_bp_skip <= 1'b1;
                end
                if (w_state_d == ST_DONE) begin
                    r_done <= 1'b1;
                end
                r_prev_en <= w_exec;
            end
        end
    end

`ifdef CPU_CTRL_WDOG_EN
    localparam int unsigned WD_W = $clog2(WDOG_LIMIT + 1);

    logic [WD_W-1:0] r_wdog_cnt;
    logic            r_wdog_err;

    assign w_wdog_fire = (r_state == ST_RUN) && (r_wdog_cnt == WD_W'(WDOG_LIMIT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wdog_cnt <= '0;
            r_wdog_err <= 1'b0;
        end else begin
            if (r_state == ST_RUN) begin
                r_wdog_cnt <= r_wdog_cnt + 1'b1;
            end else begin
                r_wdog_cnt <= '0;
            end
            if (restart_req) begin
                r_wdog_err <= 1'b0;
            end else if (r_state == ST_RUN && w_state_d == ST_ERR) begin
                r_wdog_err <= 1'b1;
            end
        end
    end

    assign wdog_err = r_wdog_err;
`else
    logic w_unused_wdog;

    assign w_unused_wdog = (WDOG_LIMIT != 0);
    assign w_wdog_fire   = 1'b0;
    assign wdog_err      = 1'b0;
`endif

    assign cpu_en      = w_cpu_en;
    assign cpu_rst     = (r_state == ST_RST);
    assign state_o     = r_state;
    assign halted      = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR);
    assign bp_hit      = w_bp_hit;
    assign done        = r_done;
    assign cycle_count = r_cycle_count;

endmodule
